// File: rtl/control_pipe_if.sv
// Handshake bundle between the IF/ID side (decode inputs, hazard controls, syscall ack)
// and the registered ID/EX control outputs of control_pipe_unit.
interface control_pipe_if #(
    parameter int ALU_OP_W = 4,
    parameter int BV_W     = 3
);
    logic                id_valid;
    logic [5:0]          opcode;
    logic [5:0]          funct;
    logic [4:0]          reg_rt_id;
    logic                stall_in;
    logic                flush_in;
    logic                syscall_ack;

    logic                ex_valid;
    logic                ex_reg_write;
    logic                ex_mem_to_reg;
    logic                ex_mem_write;
    logic                ex_alu_src;
    logic                ex_reg_dest;
    logic [ALU_OP_W-1:0] ex_alu_op;
    logic [BV_W-1:0]     ex_branch_var;
    logic                ex_md_start;
    logic                id_busy;
    logic                syscall_req;

    modport master (
        output id_valid, opcode, funct, reg_rt_id, stall_in, flush_in, syscall_ack,
        input  ex_valid, ex_reg_write, ex_mem_to_reg, ex_mem_write, ex_alu_src,
               ex_reg_dest, ex_alu_op, ex_branch_var, ex_md_start, id_busy, syscall_req
    );

    modport slave (
        input  id_valid, opcode, funct, reg_rt_id, stall_in, flush_in, syscall_ack,
        output ex_valid, ex_reg_write, ex_mem_to_reg, ex_mem_write, ex_alu_src,
               ex_reg_dest, ex_alu_op, ex_branch_var, ex_md_start, id_busy, syscall_req
    );
endinterface

// File: rtl/control_pipe_unit.sv
// Decode-stage control unit: decodes the instruction into a control bundle held in the
// ID/EX register, with stall/flush handling, a MULT/DIV busy window and a SYSCALL drain/request FSM.
module control_pipe_unit #(
    parameter int ALU_OP_W     = 4,
    parameter int BV_W         = 3,
    parameter int MD_LATENCY   = 32,
    parameter int DRAIN_CYCLES = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    control_pipe_if.slave bus
);
    localparam int CNT_MAX = (MD_LATENCY > DRAIN_CYCLES) ? MD_LATENCY : DRAIN_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [5:0] OP_SPECIAL = 6'h00, OP_REGIMM = 6'h01, OP_J   = 6'h02,
                           OP_JAL     = 6'h03, OP_BEQ    = 6'h04, OP_BNE = 6'h05,
                           OP_ADDIU   = 6'h09, OP_ORI    = 6'h0D, OP_LUI = 6'h0F,
                           OP_LW      = 6'h23, OP_SB     = 6'h28, OP_SW  = 6'h2B;
    localparam logic [5:0] FN_JR = 6'h08, FN_SYSCALL = 6'h0C;
    localparam logic [4:0] RT_BLTZ = 5'd0;

    localparam logic [ALU_OP_W-1:0] ALU_NOP   = ALU_OP_W'(0), ALU_ADD = ALU_OP_W'(1),
                                    ALU_SUB   = ALU_OP_W'(2), ALU_OR  = ALU_OP_W'(3),
                                    ALU_LUI   = ALU_OP_W'(4), ALU_RTYPE = ALU_OP_W'(5);
    localparam logic [BV_W-1:0] BV_NONE = BV_W'(0), BV_BLTZ = BV_W'(1), BV_J   = BV_W'(2),
                                BV_JAL  = BV_W'(3), BV_JUMP_REG = BV_W'(4),
                                BV_BEQ  = BV_W'(5), BV_BNE = BV_W'(6);

    typedef struct packed {
        logic                reg_write;
        logic                mem_to_reg;
        logic                mem_write;
        logic                alu_src;
        logic                reg_dest;
        logic [ALU_OP_W-1:0] alu_op;
        logic [BV_W-1:0]     branch_var;
    } ctrl_t;

    typedef enum logic [1:0] {S_IDLE, S_MD_BUSY, S_SYS_DRAIN, S_SYS_WAIT} state_t;

    ctrl_t             dec;
    ctrl_t             ex_ctrl;
    logic              is_md;
    logic              is_sys;
    logic              load_fire;
    logic              ex_valid;
    logic              ex_md_start;
    logic              syscall_req;
    state_t            state;
    logic [CNT_W-1:0]  cnt;

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        dec    = '0;
        is_md  = 1'b0;
        is_sys = 1'b0;
        case (bus.opcode)
            OP_SPECIAL: begin
                // SYSCALL travels down the pipe as a valid NOP; the FSM does the real work.
                if (bus.funct == FN_SYSCALL) begin
                    is_sys = 1'b1;
                end else begin
                    dec.reg_dest = 1'b1;
                    dec.alu_op   = ALU_RTYPE;
                    is_md        = (bus.funct[5:2] == 4'b0110);
                    if (bus.funct == FN_JR) dec.branch_var = BV_JUMP_REG;
                    else                    dec.reg_write  = !is_md;
                end
            end
            OP_REGIMM: begin
                if (bus.reg_rt_id == RT_BLTZ) begin
                    dec.branch_var = BV_BLTZ;
                    dec.alu_op     = ALU_SUB;
                end
            end
            OP_J:     dec.branch_var = BV_J;
            OP_JAL: begin
                dec.branch_var = BV_JAL;
                dec.reg_write  = 1'b1;
            end
            OP_BEQ: begin
                dec.branch_var = BV_BEQ;
                dec.alu_op     = ALU_SUB;
            end
            OP_BNE: begin
                dec.branch_var = BV_BNE;
                dec.alu_op     = ALU_SUB;
            end
            OP_ADDIU: begin
                dec.reg_write = 1'b1;
                dec.alu_src   = 1'b1;
                dec.alu_op    = ALU_ADD;
            end
            OP_ORI: begin
                dec.reg_write = 1'b1;
                dec.alu_src   = 1'b1;
                dec.alu_op    = ALU_OR;
            end
            OP_LUI: begin
                dec.reg_write = 1'b1;
                dec.alu_src   = 1'b1;
                dec.alu_op    = ALU_LUI;
            end
            OP_LW: begin
                dec.reg_write  = 1'b1;
                dec.mem_to_reg = 1'b1;
                dec.alu_src    = 1'b1;
                dec.alu_op     = ALU_ADD;
            end
            OP_SW, OP_SB: begin
                dec.mem_write = 1'b1;
                dec.alu_src   = 1'b1;
                dec.alu_op    = ALU_ADD;
            end
            default: dec = '0;
        endcase
    end

    assign bus.id_busy = (state != S_IDLE);
    assign load_fire   = bus.id_valid && !bus.id_busy && !bus.stall_in && !bus.flush_in;

    // NOTE: all state is updated with non-blocking assignments under an asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid    <= 1'b0;
            ex_ctrl     <= '0;
            ex_md_start <= 1'b0;
            syscall_req <= 1'b0;
            state       <= S_IDLE;
            cnt         <= '0;
        end else begin
            if (bus.flush_in) begin
                ex_valid    <= 1'b0;
                ex_ctrl     <= '0;
                ex_md_start <= 1'b0;
            end else if (bus.stall_in) begin
                ex_md_start <= 1'b0;
            end else if (load_fire) begin
                ex_valid    <= 1'b1;
                ex_ctrl     <= dec;
                ex_md_start <= is_md;
            end else begin
                ex_valid    <= 1'b0;
                ex_ctrl     <= '0;
                ex_md_start <= 1'b0;
            end

            // The FSM only leaves IDLE on an accepted load, so flush/stall there squash the op.
            case (state)
                S_IDLE: begin
                    if (load_fire && is_md) begin
                        cnt   <= CNT_W'(MD_LATENCY - 1);
                        state <= S_MD_BUSY;
                    end else if (load_fire && is_sys) begin
                        cnt   <= CNT_W'(DRAIN_CYCLES - 1);
                        state <= S_SYS_DRAIN;
                    end
                end
                S_MD_BUSY: begin
                    if (cnt == '0) state <= S_IDLE;
                    else           cnt   <= cnt - CNT_W'(1);
                end
                S_SYS_DRAIN: begin
                    if (cnt == '0) begin
                        state       <= S_SYS_WAIT;
                        syscall_req <= 1'b1;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                S_SYS_WAIT: begin
                    if (bus.syscall_ack) begin
                        syscall_req <= 1'b0;
                        state       <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.ex_valid      = ex_valid;
    assign bus.ex_reg_write  = ex_ctrl.reg_write;
    assign bus.ex_mem_to_reg = ex_ctrl.mem_to_reg;
    assign bus.ex_mem_write  = ex_ctrl.mem_write;
    assign bus.ex_alu_src    = ex_ctrl.alu_src;
    assign bus.ex_reg_dest   = ex_ctrl.reg_dest;
    assign bus.ex_alu_op     = ex_ctrl.alu_op;
    assign bus.ex_branch_var = ex_ctrl.branch_var;
    assign bus.ex_md_start   = ex_md_start;
    assign bus.syscall_req   = syscall_req;
endmodule

// File: tb/tb_control_pipe_unit.sv
// Self-checking bench for control_pipe_unit: decode vector table, hand-written multi-cycle
// sequences, and randomized traffic compared against a cycle-count reference model.
module tb_control_pipe_unit;
    localparam int MD_LATENCY   = 4;
    localparam int DRAIN_CYCLES = 3;

    localparam logic [5:0] OP_SPECIAL = 6'h00, OP_REGIMM = 6'h01, OP_J   = 6'h02,
                           OP_JAL     = 6'h03, OP_BEQ    = 6'h04, OP_BNE = 6'h05,
                           OP_ADDIU   = 6'h09, OP_ORI    = 6'h0D, OP_LUI = 6'h0F,
                           OP_LW      = 6'h23, OP_SB     = 6'h28, OP_SW  = 6'h2B;
    localparam logic [5:0] FN_JR = 6'h08, FN_SYSCALL = 6'h0C, FN_MULT = 6'h18,
                           FN_MULTU = 6'h19, FN_DIV = 6'h1A, FN_DIVU = 6'h1B, FN_ADD = 6'h20;
    localparam logic [3:0] ALU_NOP = 4'd0, ALU_ADD = 4'd1, ALU_SUB = 4'd2,
                           ALU_OR  = 4'd3, ALU_LUI = 4'd4, ALU_RTYPE = 4'd5;
    localparam logic [2:0] BV_NONE = 3'd0, BV_BLTZ = 3'd1, BV_J = 3'd2, BV_JAL = 3'd3,
                           BV_JUMP_REG = 3'd4, BV_BEQ = 3'd5, BV_BNE = 3'd6;

    typedef struct packed {
        logic       valid, rw, mtr, mw, src, rd;
        logic [3:0] alu;
        logic [2:0] bv;
        logic       md_start, busy, req;
    } obs_t;

    typedef struct {
        logic       v;
        logic [5:0] op, fn;
        logic [4:0] rt;
        logic       st, fl;
        obs_t       exp;
    } vec_t;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_bad;

    control_pipe_if #(.ALU_OP_W(4), .BV_W(3)) bus ();

    control_pipe_unit #(
        .ALU_OP_W(4), .BV_W(3), .MD_LATENCY(MD_LATENCY), .DRAIN_CYCLES(DRAIN_CYCLES)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: busy windows expressed as edge-number deadlines.
    int   edge_no    = 0;
    int   md_until   = 0;
    int   req_from   = 0;
    bit   sys_active = 1'b0;
    obs_t m_ex       = '0;
    bit   m_md       = 1'b0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic obs_t mk(input logic v, rw, mtr, mw, src, rd,
                                input logic [3:0] alu, input logic [2:0] bv);
        obs_t o = '0;
        o.valid = v; o.rw = rw; o.mtr = mtr; o.mw = mw; o.src = src; o.rd = rd;
        o.alu = alu; o.bv = bv;
        return o;
    endfunction

    function automatic obs_t sample();
        obs_t o;
        o.valid    = bus.ex_valid;
        o.rw       = bus.ex_reg_write;
        o.mtr      = bus.ex_mem_to_reg;
        o.mw       = bus.ex_mem_write;
        o.src      = bus.ex_alu_src;
        o.rd       = bus.ex_reg_dest;
        o.alu      = bus.ex_alu_op;
        o.bv       = bus.ex_branch_var;
        o.md_start = bus.ex_md_start;
        o.busy     = bus.id_busy;
        o.req      = bus.syscall_req;
        return o;
    endfunction

    function automatic void ref_decode(input logic [5:0] op, fn, input logic [4:0] rt,
                                       output obs_t b, output bit md, output bit sys);
        b = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ALU_NOP, BV_NONE);
        md = 1'b0;
        sys = 1'b0;
        case (op)
            OP_SPECIAL: begin
                sys = (fn == FN_SYSCALL);
                md  = fn inside {FN_MULT, FN_MULTU, FN_DIV, FN_DIVU};
                if (!sys) begin
                    b.rd  = 1'b1;
                    b.alu = ALU_RTYPE;
                    b.rw  = !md && (fn != FN_JR);
                    if (fn == FN_JR) b.bv = BV_JUMP_REG;
                end
            end
            OP_REGIMM: if (rt == 5'd0) begin b.bv = BV_BLTZ; b.alu = ALU_SUB; end
            OP_J:      b.bv = BV_J;
            OP_JAL:    begin b.bv = BV_JAL; b.rw = 1'b1; end
            OP_BEQ:    begin b.bv = BV_BEQ; b.alu = ALU_SUB; end
            OP_BNE:    begin b.bv = BV_BNE; b.alu = ALU_SUB; end
            OP_ADDIU:  b = mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, ALU_ADD, BV_NONE);
            OP_ORI:    b = mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, ALU_OR,  BV_NONE);
            OP_LUI:    b = mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, ALU_LUI, BV_NONE);
            OP_LW:     b = mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, ALU_ADD, BV_NONE);
            OP_SW, OP_SB: b = mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, ALU_ADD, BV_NONE);
            default: ;
        endcase
    endfunction

    function automatic bit model_busy();
        return (edge_no < md_until) || sys_active;
    endfunction

    function automatic bit model_req();
        return sys_active && (edge_no >= req_from);
    endfunction

    function automatic void model_reset();
        md_until   = edge_no;
        sys_active = 1'b0;
        m_ex       = '0;
        m_md       = 1'b0;
    endfunction

    task automatic drive(input logic v, input logic [5:0] op, fn, input logic [4:0] rt,
                         input logic st, fl, ack);
        bus.id_valid    = v;
        bus.opcode      = op;
        bus.funct       = fn;
        bus.reg_rt_id   = rt;
        bus.stall_in    = st;
        bus.flush_in    = fl;
        bus.syscall_ack = ack;
    endtask

    // One clock edge: advance the model from the pre-edge inputs, then compare after the edge.
    task automatic step();
        obs_t dec, expv;
        bit   md, sys, busy_pre, req_pre, load;
        busy_pre = model_busy();
        req_pre  = model_req();
        ref_decode(bus.opcode, bus.funct, bus.reg_rt_id, dec, md, sys);
        load = bus.id_valid && !busy_pre && !bus.stall_in && !bus.flush_in;
        if (bus.flush_in)      begin m_ex = '0; m_md = 1'b0; end
        else if (bus.stall_in) m_md = 1'b0;
        else if (load)         begin m_ex = dec; m_md = md; end
        else                   begin m_ex = '0; m_md = 1'b0; end
        if (req_pre && bus.syscall_ack) sys_active = 1'b0;
        @(posedge clk);
        edge_no++;
        if (load && md) md_until = edge_no + MD_LATENCY;
        if (load && sys) begin
            sys_active = 1'b1;
            req_from   = edge_no + DRAIN_CYCLES;
        end
        #1;
        expv          = m_ex;
        expv.md_start = m_md;
        expv.busy     = model_busy();
        expv.req      = model_req();
        check($sformatf("model_edge%0d", edge_no), sample(), expv);
    endtask

    logic [5:0] op_pool [13] = '{OP_SPECIAL, OP_SPECIAL, OP_REGIMM, OP_J, OP_JAL, OP_BEQ,
                                 OP_BNE, OP_ADDIU, OP_ORI, OP_LUI, OP_LW, OP_SW, OP_SB};
    logic [5:0] fn_pool [8]  = '{FN_ADD, FN_JR, FN_SYSCALL, FN_MULT, FN_MULTU, FN_DIV,
                                 FN_DIVU, 6'h21};

    initial begin
        vec_t       vecs [17];
        obs_t       e;
        logic [5:0] busy_pat, md_pat;
        logic [7:0] req_pat, sbusy_pat;

        n_vec = 0;
        n_bad = 0;
        rst_n = 1'b0;
        drive(1'b0, 6'h00, 6'h00, 5'd0, 1'b0, 1'b0, 1'b0);

        vecs[0]  = '{1'b1, OP_LW,     6'h00,      5'd0, 1'b0, 1'b0, mk(1,1,1,0,1,0, ALU_ADD,   BV_NONE)};
        vecs[1]  = '{1'b1, OP_SW,     6'h00,      5'd0, 1'b0, 1'b0, mk(1,0,0,1,1,0, ALU_ADD,   BV_NONE)};
        vecs[2]  = '{1'b1, OP_BEQ,    6'h00,      5'd0, 1'b0, 1'b0, mk(1,0,0,0,0,0, ALU_SUB,   BV_BEQ)};
        vecs[3]  = '{1'b1, OP_BNE,    6'h00,      5'd0, 1'b0, 1'b0, mk(1,0,0,0,0,0, ALU_SUB,   BV_BNE)};
        vecs[4]  = '{1'b1, OP_ADDIU,  6'h00,      5'd0, 1'b0, 1'b0, mk(1,1,0,0,1,0, ALU_ADD,   BV_NONE)};
        vecs[5]  = '{1'b1, OP_ORI,    6'h00,      5'd0, 1'b0, 1'b0, mk(1,1,0,0,1,0, ALU_OR,    BV_NONE)};
        vecs[6]  = '{1'b1, OP_LUI,    6'h00,      5'd0, 1'b0, 1'b0, mk(1,1,0,0,1,0, ALU_LUI,   BV_NONE)};
        vecs[7]  = '{1'b1, OP_SB,     6'h00,      5'd0, 1'b0, 1'b0, mk(1,0,0,1,1,0, ALU_ADD,   BV_NONE)};
        vecs[8]  = '{1'b1, OP_J,      6'h00,      5'd0, 1'b0, 1'b0, mk(1,0,0,0,0,0, ALU_NOP,   BV_J)};
        vecs[9]  = '{1'b1, OP_JAL,    6'h00,      5'd0, 1'b0, 1'b0, mk(1,1,0,0,0,0, ALU_NOP,   BV_JAL)};
        vecs[10] = '{1'b1, OP_SPECIAL, FN_ADD,    5'd0, 1'b0, 1'b0, mk(1,1,0,0,0,1, ALU_RTYPE, BV_NONE)};
        vecs[11] = '{1'b1, OP_SPECIAL, FN_JR,     5'd0, 1'b0, 1'b0, mk(1,0,0,0,0,1, ALU_RTYPE, BV_JUMP_REG)};
        vecs[12] = '{1'b1, OP_REGIMM, 6'h00,      5'd0, 1'b0, 1'b0, mk(1,0,0,0,0,0, ALU_SUB,   BV_BLTZ)};
        vecs[13] = '{1'b1, OP_REGIMM, 6'h00,      5'd1, 1'b0, 1'b0, mk(1,0,0,0,0,0, ALU_NOP,   BV_NONE)};
        vecs[14] = '{1'b1, 6'h3F,     6'h00,      5'd0, 1'b0, 1'b0, mk(1,0,0,0,0,0, ALU_NOP,   BV_NONE)};
        vecs[15] = '{1'b0, OP_LW,     6'h00,      5'd0, 1'b0, 1'b0, mk(0,0,0,0,0,0, ALU_NOP,   BV_NONE)};
        vecs[16] = '{1'b1, OP_LW,     6'h00,      5'd0, 1'b0, 1'b1, mk(0,0,0,0,0,0, ALU_NOP,   BV_NONE)};

        #3 check("reset_state", sample(), '0);
        #4 rst_n = 1'b1;
        model_reset();

        foreach (vecs[i]) begin
            drive(vecs[i].v, vecs[i].op, vecs[i].fn, vecs[i].rt, vecs[i].st, vecs[i].fl, 1'b0);
            step();
            check($sformatf("vec%0d", i), sample(), vecs[i].exp);
        end

        // ADDIU held through two stall cycles, then flush wins over stall.
        drive(1'b1, OP_ADDIU, 6'h00, 5'd0, 1'b0, 1'b0, 1'b0);
        step();
        for (int k = 0; k < 2; k++) begin
            drive(1'b1, OP_LW, 6'h00, 5'd0, 1'b1, 1'b0, 1'b0);
            step();
            check($sformatf("stall_hold%0d", k), sample(), mk(1,1,0,0,1,0, ALU_ADD, BV_NONE));
        end
        drive(1'b1, OP_LW, 6'h00, 5'd0, 1'b1, 1'b1, 1'b0);
        step();
        check("stall_flush", sample(), '0);

        // Stalled MULT must not start the busy window.
        drive(1'b1, OP_SPECIAL, FN_MULT, 5'd0, 1'b1, 1'b0, 1'b0);
        step();
        check("md_stalled", {14'd0, bus.ex_md_start, bus.id_busy}, 16'd0);

        // MULT held in ID: issues, busy for MD_LATENCY cycles, then the second MULT issues.
        drive(1'b1, OP_SPECIAL, FN_MULT, 5'd0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 6; k++) begin
            step();
            busy_pat[k] = bus.id_busy;
            md_pat[k]   = bus.ex_md_start;
        end
        check("md_busy_pattern", 16'(busy_pat), 16'(6'b101111));
        check("md_start_pattern", 16'(md_pat), 16'(6'b100001));
        drive(1'b0, 6'h00, 6'h00, 5'd0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) step();
        check("md_done_idle", 16'(bus.id_busy), 16'd0);

        // Flush on the SYSCALL load edge squashes it.
        drive(1'b1, OP_SPECIAL, FN_SYSCALL, 5'd0, 1'b0, 1'b1, 1'b0);
        step();
        check("sys_flushed", sample(), '0);

        // SYSCALL: NOP bundle, req after drain, early ack ignored, ack in wait clears.
        drive(1'b1, OP_SPECIAL, FN_SYSCALL, 5'd0, 1'b0, 1'b0, 1'b0);
        step();
        e = mk(1,0,0,0,0,0, ALU_NOP, BV_NONE);
        e.busy = 1'b1;
        check("sys_load", sample(), e);
        for (int s = 1; s <= 8; s++) begin
            drive(1'b0, 6'h00, 6'h00, 5'd0, 1'b0, 1'b0, (s == 1) || (s == 8));
            step();
            req_pat[s-1]   = bus.syscall_req;
            sbusy_pat[s-1] = bus.id_busy;
        end
        check("sys_req_pattern", 16'(req_pat), 16'(8'b0111_1100));
        check("sys_busy_pattern", 16'(sbusy_pat), 16'(8'b0111_1111));
        drive(1'b0, 6'h00, 6'h00, 5'd0, 1'b0, 1'b0, 1'b0);

        // Async reset in the middle of an MD busy window.
        drive(1'b1, OP_SPECIAL, FN_DIV, 5'd0, 1'b0, 1'b0, 1'b0);
        step();
        drive(1'b0, 6'h00, 6'h00, 5'd0, 1'b0, 1'b0, 1'b0);
        step();
        #2 rst_n = 1'b0;
        #1 check("async_reset_mid_md", sample(), '0);
        #2 rst_n = 1'b1;
        model_reset();

        for (int k = 0; k < 1500; k++) begin
            logic [5:0] op, fn;
            op = ($urandom_range(0, 15) == 0) ? 6'($urandom) : op_pool[$urandom_range(0, 12)];
            fn = fn_pool[$urandom_range(0, 7)];
            drive($urandom_range(0, 3) != 0, op, fn, 5'($urandom_range(0, 2)),
                  $urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0,
                  $urandom_range(0, 3) == 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
